uart_mem_sequencer: RTL and testbench

Parametrised controller for the load / process / dump flow around the shared image RAM. It writes a fixed-length byte stream from the UART receiver into RAM, then hands the RAM to the processor and enables its run gating. When the processor reports completion, it reads a configurable RAM window back out through the UART transmitter. It sits between `uart_rx`/`uart_tx`, the RAM port mux and the processor clock gate, and supersedes ad-hoc address/`wea` logic in the top level.

---
 rtl/seq_pkg.sv | 16 +
 rtl/dump_reader.sv | 90 +++++++++
 rtl/uart_mem_sequencer.sv | 151 +++++++++++++++
 tb/tb_uart_mem_sequencer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared state encoding and RAM ownership constants for the UART load / process / dump sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        StLoad     = 3'd0,
        StRun      = 3'd1,
        StDumpRd   = 3'd2,
        StDumpTx   = 3'd3,
        StDumpWait = 3'd4,
        StDone     = 3'd5
    } seq_state_e;

    localparam logic MEM_SEL_SEQ  = 1'b0;
    localparam logic MEM_SEL_PROC = 1'b1;

endpackage

// File: rtl/dump_reader.sv
// Reads the dump window from RAM one byte at a time and hands each byte to the UART transmitter.
module dump_reader
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DUMP_BASE = 0,
    parameter int unsigned DUMP_LEN  = 63516,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              tx_done_tick,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output seq_state_e        phase,
    output logic              done
);

    localparam int unsigned        CntW     = ADDR_W + 1;
    localparam logic [CntW-1:0]   DumpLast = CntW'(DUMP_LEN - 1);
    localparam logic [ADDR_W-1:0] DumpBase = ADDR_W'(DUMP_BASE);
    localparam logic [1:0]        LatLast  = 2'(RD_LAT);

    // StDone doubles as the idle phase between dumps.
    seq_state_e        phase_q;
    logic [1:0]        lat_q;
    logic [CntW-1:0]   dump_cnt_q;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q    <= StDone;
            lat_q      <= '0;
            dump_cnt_q <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (phase_q)
                StDone: begin
                    if (start) begin
                        phase_q    <= StDumpRd;
                        lat_q      <= '0;
                        dump_cnt_q <= '0;
                    end
                end
                // Address is held for RD_LAT+1 cycles; ram_dout is valid in the last one.
                StDumpRd: begin
                    if (lat_q == LatLast) begin
                        tx_data_q  <= ram_dout;
                        tx_start_q <= 1'b1;
                        phase_q    <= StDumpTx;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                StDumpTx: begin
                    phase_q <= StDumpWait;
                end
                StDumpWait: begin
                    if (tx_done_tick) begin
                        if (dump_cnt_q == DumpLast) begin
                            dump_cnt_q <= '0;
                            phase_q    <= StDone;
                        end else begin
                            dump_cnt_q <= dump_cnt_q + CntW'(1);
                            lat_q      <= '0;
                            phase_q    <= StDumpRd;
                        end
                    end
                end
                default: begin
                    phase_q <= StDone;
                end
            endcase
        end
    end

    assign rd_addr  = DumpBase + dump_cnt_q[ADDR_W-1:0];
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign phase    = phase_q;
    assign done     = (phase_q == StDumpWait) && tx_done_tick && (dump_cnt_q == DumpLast);

endmodule

// File: rtl/uart_mem_sequencer.sv
// Load / process / dump controller: UART bytes into RAM, processor run gating, RAM window back out.
module uart_mem_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned LOAD_LEN     = 63516,
    parameter int unsigned DUMP_BASE    = 0,
    parameter int unsigned DUMP_LEN     = 63516,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned AUTO_RESTART = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              proc_finished,
    output logic              proc_run,
    output logic              mem_sel,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [2:0]        state_o,
    output logic              overrun
);

    localparam int unsigned      CntW        = ADDR_W + 1;
    localparam logic [CntW-1:0] LoadLast    = CntW'(LOAD_LEN - 1);
    localparam bit              AutoRestart = (AUTO_RESTART != 0);

    // The top FSM only uses StDumpRd as "dump loop active"; the reader tracks the sub-phase.
    seq_state_e      state_q;
    logic [CntW-1:0] load_cnt_q;
    logic            proc_run_q;
    logic            mem_sel_q;
    logic            overrun_q;

    logic              rd_start;
    logic              rd_done;
    logic [ADDR_W-1:0] rd_addr;
    seq_state_e        rd_phase;
    logic              load_wr;

    assign rd_start = (state_q == StRun) && proc_finished;

    dump_reader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DUMP_BASE(DUMP_BASE),
        .DUMP_LEN (DUMP_LEN),
        .RD_LAT   (RD_LAT)
    ) u_dump_reader (
        .clk         (clk),
        .reset       (reset),
        .start       (rd_start),
        .tx_done_tick(tx_done_tick),
        .ram_dout    (ram_dout),
        .rd_addr     (rd_addr),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .phase       (rd_phase),
        .done        (rd_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StLoad;
            load_cnt_q <= '0;
            proc_run_q <= 1'b0;
            mem_sel_q  <= MEM_SEL_SEQ;
            overrun_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (rx_done_tick) begin
                        if (load_cnt_q == LoadLast) begin
                            state_q    <= StRun;
                            load_cnt_q <= '0;
                            proc_run_q <= 1'b1;
                            mem_sel_q  <= MEM_SEL_PROC;
                        end else begin
                            load_cnt_q <= load_cnt_q + CntW'(1);
                        end
                    end
                end
                StRun: begin
                    if (rx_done_tick) begin
                        overrun_q <= 1'b1;
                    end
                    if (proc_finished) begin
                        state_q    <= StDumpRd;
                        proc_run_q <= 1'b0;
                        mem_sel_q  <= MEM_SEL_SEQ;
                    end
                end
                StDumpRd: begin
                    if (rx_done_tick) begin
                        overrun_q <= 1'b1;
                    end
                    if (rd_done) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (rx_done_tick) begin
                        if (!AutoRestart) begin
                            overrun_q <= 1'b1;
                        end else if (LoadLast == '0) begin
                            // Single-byte load: the restart byte completes it.
                            state_q    <= StRun;
                            load_cnt_q <= '0;
                            proc_run_q <= 1'b1;
                            mem_sel_q  <= MEM_SEL_PROC;
                        end else begin
                            state_q    <= StLoad;
                            load_cnt_q <= CntW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    // Gated by reset so the write strobe cannot leak out while reset is held.
    assign load_wr = reset && rx_done_tick &&
                     ((state_q == StLoad) || ((state_q == StDone) && AutoRestart));

    always_comb begin
        ram_addr = '0;
        if (state_q == StLoad) begin
            ram_addr = load_cnt_q[ADDR_W-1:0];
        end else if (state_q == StDumpRd) begin
            ram_addr = rd_addr;
        end
    end

    assign ram_we   = load_wr;
    assign ram_din  = load_wr ? rx_data : '0;
    assign proc_run = proc_run_q;
    assign mem_sel  = mem_sel_q;
    assign overrun  = overrun_q;
    assign state_o  = (state_q == StDumpRd) ? rd_phase : state_q;

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Randomized self-checking bench: two sequencers (dump base 2 and 14) share stimulus, each with its own RAM.
module tb_uart_mem_sequencer;

    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned LLEN = 4;
    localparam int unsigned DLEN = 4;
    localparam int unsigned RLAT = 1;
    localparam int unsigned BASE_A = 2;
    localparam int unsigned BASE_B = 14;
    localparam int unsigned MSIZE = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_done_tick = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          tx_done_tick = 1'b0;
    logic          proc_finished = 1'b0;

    logic          tx_start_a, tx_start_b, proc_run_a, proc_run_b, mem_sel_a, mem_sel_b;
    logic          ram_we_a, ram_we_b, overrun_a, overrun_b;
    logic [DW-1:0] tx_data_a, tx_data_b, ram_din_a, ram_din_b;
    logic [DW-1:0] ram_dout_a = '0;
    logic [DW-1:0] ram_dout_b = '0;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [2:0]    state_a, state_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_mem_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .LOAD_LEN(LLEN), .DUMP_BASE(BASE_A), .DUMP_LEN(DLEN),
        .RD_LAT(RLAT), .AUTO_RESTART(1)
    ) dut_a (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .tx_done_tick(tx_done_tick), .tx_start(tx_start_a), .tx_data(tx_data_a),
        .proc_finished(proc_finished), .proc_run(proc_run_a), .mem_sel(mem_sel_a),
        .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_dout(ram_dout_a),
        .state_o(state_a), .overrun(overrun_a)
    );

    uart_mem_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .LOAD_LEN(LLEN), .DUMP_BASE(BASE_B), .DUMP_LEN(DLEN),
        .RD_LAT(RLAT), .AUTO_RESTART(1)
    ) dut_b (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .tx_done_tick(tx_done_tick), .tx_start(tx_start_b), .tx_data(tx_data_b),
        .proc_finished(proc_finished), .proc_run(proc_run_b), .mem_sel(mem_sel_b),
        .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_dout(ram_dout_b),
        .state_o(state_b), .overrun(overrun_b)
    );

    logic [27:0] outs_a, outs_b;
    assign outs_a = {tx_start_a, tx_data_a, proc_run_a, mem_sel_a, ram_we_a, ram_addr_a,
                     ram_din_a, state_a, overrun_a};
    assign outs_b = {tx_start_b, tx_data_b, proc_run_b, mem_sel_b, ram_we_b, ram_addr_b,
                     ram_din_b, state_b, overrun_b};

    // RAMs with one cycle read latency; proc_fill models the processor rewriting the image.
    logic [DW-1:0] mem_a [MSIZE];
    logic [DW-1:0] mem_b [MSIZE];
    logic          proc_fill = 1'b0;
    logic [DW-1:0] fill_base = 8'hA0;

    always @(posedge clk) begin
        if (ram_we_a) mem_a[ram_addr_a] <= ram_din_a;
        else if (proc_fill && mem_sel_a) for (int i = 0; i < MSIZE; i++) mem_a[i] <= fill_base + 8'(i);
        ram_dout_a <= mem_a[ram_addr_a];
    end

    always @(posedge clk) begin
        if (ram_we_b) mem_b[ram_addr_b] <= ram_din_b;
        else if (proc_fill && mem_sel_b) for (int i = 0; i < MSIZE; i++) mem_b[i] <= fill_base + 8'(i);
        ram_dout_b <= mem_b[ram_addr_b];
    end

    // Behavioural reference: image contents as the spec says they should be.
    logic [DW-1:0] ref_mem [MSIZE];

    int            wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];
    logic [DW-1:0] tx_log_a[$];
    logic [DW-1:0] tx_log_b[$];
    int            tx_gap_log[$];
    int            rd_entry = 0;
    logic [2:0]    prev_state = 3'd0;

    always @(negedge clk) begin
        if (ram_we_a) begin
            wr_addr_log.push_back(int'(ram_addr_a));
            wr_data_log.push_back(ram_din_a);
        end
        if (state_a == 3'd2 && prev_state != 3'd2) rd_entry = cyc;
        if (tx_start_a) begin
            tx_log_a.push_back(tx_data_a);
            tx_gap_log.push_back(cyc - rd_entry);
        end
        if (tx_start_b) tx_log_b.push_back(tx_data_b);
        prev_state = state_a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [DW-1:0] b);
        rx_data = b;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
    endtask

    // Sends a full load of LLEN bytes starting at index first and checks the resulting writes.
    task automatic load_bytes(input string tag, input int first);
        int w0 = wr_addr_log.size();
        logic [DW-1:0] b;
        for (int i = first; i < int'(LLEN); i++) begin
            repeat ($urandom_range(0, 2)) tick();
            b = 8'($urandom);
            ref_mem[i] = b;
            send_rx(b);
        end
        total_cnt++;
        if (wr_addr_log.size() !== w0 + int'(LLEN) - first)
            $display("FAIL %s write count: got %0d required %0d", tag, wr_addr_log.size() - w0,
                     int'(LLEN) - first);
        else begin
            pass_cnt++;
            for (int i = first; i < int'(LLEN); i++) begin
                total_cnt++;
                if (wr_addr_log[w0 + i - first] !== i || wr_data_log[w0 + i - first] !== ref_mem[i])
                    $display("FAIL %s write %0d: got addr %0d data %h required addr %0d data %h", tag,
                             i, wr_addr_log[w0 + i - first], wr_data_log[w0 + i - first], i, ref_mem[i]);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (state_a !== 3'd1 || proc_run_a !== 1'b1 || mem_sel_a !== 1'b1)
            $display("FAIL %s enter run: got state %0d proc_run %b mem_sel %b required 1 1 1", tag,
                     state_a, proc_run_a, mem_sel_a);
        else pass_cnt++;
    endtask

    // Drives a complete dump from DUMP_RD entry and checks both byte streams and timing.
    task automatic do_dump(input string tag, input bit poke);
        int a0 = tx_log_a.size();
        int b0 = tx_log_b.size();
        int g0 = tx_gap_log.size();
        int n;
        for (int i = 0; i < int'(DLEN); i++) begin
            n = 0;
            while (!tx_start_a && n < 64) begin
                tick();
                n++;
            end
            if (!tx_start_a) begin
                total_cnt++;
                $display("FAIL %s tx_start timeout byte %0d: got none required one within 64 cycles",
                         tag, i);
                return;
            end
            // A done tick during DUMP_TX must be ignored.
            tx_done_tick = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            tx_done_tick = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            tx_done_tick = 1'b1;
            tick();
            tx_done_tick = 1'b0;
        end
        total_cnt++;
        if (state_a !== 3'd5 || state_b !== 3'd5)
            $display("FAIL %s end state: got %0d/%0d required 5/5", tag, state_a, state_b);
        else pass_cnt++;
        total_cnt++;
        if (tx_log_a.size() !== a0 + int'(DLEN) || tx_log_b.size() !== b0 + int'(DLEN))
            $display("FAIL %s tx count: got %0d/%0d required %0d", tag, tx_log_a.size() - a0,
                     tx_log_b.size() - b0, DLEN);
        else begin
            pass_cnt++;
            for (int i = 0; i < int'(DLEN); i++) begin
                total_cnt++;
                if (tx_log_a[a0 + i] !== ref_mem[(int'(BASE_A) + i) % MSIZE])
                    $display("FAIL %s tx_data byte %0d: got %h required %h", tag, i, tx_log_a[a0 + i],
                             ref_mem[(int'(BASE_A) + i) % MSIZE]);
                else pass_cnt++;
                total_cnt++;
                if (tx_log_b[b0 + i] !== ref_mem[(int'(BASE_B) + i) % MSIZE])
                    $display("FAIL %s wrap tx_data byte %0d: got %h required %h", tag, i,
                             tx_log_b[b0 + i], ref_mem[(int'(BASE_B) + i) % MSIZE]);
                else pass_cnt++;
                total_cnt++;
                if (tx_gap_log[g0 + i] !== int'(RLAT) + 1)
                    $display("FAIL %s tx_start latency byte %0d: got %0d required %0d", tag, i,
                             tx_gap_log[g0 + i], RLAT + 1);
                else pass_cnt++;
            end
        end
    endtask

    task automatic start_dump(input string tag);
        proc_finished = 1'b1;
        tick();
        proc_finished = 1'b0;
        total_cnt++;
        if (state_a !== 3'd2 || proc_run_a !== 1'b0 || mem_sel_a !== 1'b0)
            $display("FAIL %s dump entry: got state %0d proc_run %b mem_sel %b required 2 0 0", tag,
                     state_a, proc_run_a, mem_sel_a);
        else pass_cnt++;
        total_cnt++;
        if (ram_addr_a !== AW'(BASE_A) || ram_addr_b !== AW'(BASE_B))
            $display("FAIL %s first read addr: got %0d/%0d required %0d/%0d", tag, ram_addr_a,
                     ram_addr_b, BASE_A, BASE_B);
        else pass_cnt++;
    endtask

    task automatic processor_fill(input logic [DW-1:0] fb);
        fill_base = fb;
        proc_fill = 1'b1;
        tick();
        proc_fill = 1'b0;
        for (int i = 0; i < MSIZE; i++) ref_mem[i] = fb + 8'(i);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (outs_a !== '0 || outs_b !== '0)
            $display("FAIL reset outputs: got %h/%h required 0", outs_a, outs_b);
        else pass_cnt++;
        repeat (2) tick();
        total_cnt++;
        if (outs_a !== '0 || outs_b !== '0)
            $display("FAIL reset held outputs: got %h/%h required 0", outs_a, outs_b);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++;
        if (state_a !== 3'd0 || outs_a !== '0)
            $display("FAIL reset release: got state %0d outs %h required 0 0", state_a, outs_a);
        else pass_cnt++;
    endtask

    task automatic test_load();
        logic [DW-1:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int w0 = wr_addr_log.size();
        for (int i = 0; i < int'(LLEN); i++) begin
            repeat ($urandom_range(0, 2)) tick();
            total_cnt++;
            if (proc_run_a !== 1'b0 || state_a !== 3'd0)
                $display("FAIL load early run byte %0d: got proc_run %b state %0d required 0 0", i,
                         proc_run_a, state_a);
            else pass_cnt++;
            ref_mem[i] = bytes[i];
            send_rx(bytes[i]);
        end
        total_cnt++;
        if (proc_run_a !== 1'b1 || state_a !== 3'd1)
            $display("FAIL load proc_run after last write: got %b state %0d required 1 1", proc_run_a,
                     state_a);
        else pass_cnt++;
        total_cnt++;
        if (wr_addr_log.size() !== w0 + int'(LLEN))
            $display("FAIL load write count: got %0d required %0d", wr_addr_log.size() - w0, LLEN);
        else begin
            pass_cnt++;
            for (int i = 0; i < int'(LLEN); i++) begin
                total_cnt++;
                if (wr_addr_log[w0 + i] !== i || wr_data_log[w0 + i] !== bytes[i])
                    $display("FAIL load write %0d: got addr %0d data %h required addr %0d data %h", i,
                             wr_addr_log[w0 + i], wr_data_log[w0 + i], i, bytes[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_run_dump();
        processor_fill(8'hA0);
        start_dump("run_dump");
        do_dump("run_dump", 1'b0);
    endtask

    task automatic test_restart();
        int w0;
        proc_finished = 1'b1;
        tick();
        proc_finished = 1'b0;
        total_cnt++;
        if (state_a !== 3'd5 || proc_run_a !== 1'b0)
            $display("FAIL restart stray proc_finished: got state %0d proc_run %b required 5 0",
                     state_a, proc_run_a);
        else pass_cnt++;
        w0 = wr_addr_log.size();
        ref_mem[0] = 8'h55;
        send_rx(8'h55);
        total_cnt++;
        if (wr_addr_log.size() !== w0 + 1 || state_a !== 3'd0)
            $display("FAIL restart first byte: got %0d writes state %0d required 1 write state 0",
                     wr_addr_log.size() - w0, state_a);
        else begin
            pass_cnt++;
            total_cnt++;
            if (wr_addr_log[w0] !== 0 || wr_data_log[w0] !== 8'h55)
                $display("FAIL restart write: got addr %0d data %h required addr 0 data 55",
                         wr_addr_log[w0], wr_data_log[w0]);
            else pass_cnt++;
        end
        load_bytes("restart", 1);
    endtask

    task automatic test_overrun();
        int w0 = wr_addr_log.size();
        total_cnt++;
        if (overrun_a !== 1'b0)
            $display("FAIL overrun before: got %b required 0", overrun_a);
        else pass_cnt++;
        send_rx(8'($urandom));
        total_cnt++;
        if (wr_addr_log.size() !== w0 || overrun_a !== 1'b1 || state_a !== 3'd1)
            $display("FAIL overrun in run: got %0d writes overrun %b state %0d required 0 1 1",
                     wr_addr_log.size() - w0, overrun_a, state_a);
        else pass_cnt++;
        start_dump("overrun");
        send_rx(8'($urandom));
        do_dump("overrun", 1'b1);
        total_cnt++;
        if (overrun_a !== 1'b1 || wr_addr_log.size() !== w0)
            $display("FAIL overrun sticky: got overrun %b writes %0d required 1 0", overrun_a,
                     wr_addr_log.size() - w0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            load_bytes("back_to_back", 0);
            processor_fill(8'($urandom));
            start_dump("back_to_back");
            do_dump("back_to_back", 1'b1);
        end
    endtask

    task automatic test_reset_mid_dump();
        int n = 0;
        int t0;
        int w0;
        logic [DW-1:0] b;
        load_bytes("reset_mid", 0);
        start_dump("reset_mid");
        while (!tx_start_a && n < 64) begin
            tick();
            n++;
        end
        tick();
        total_cnt++;
        if (state_a !== 3'd4)
            $display("FAIL reset_mid reach wait: got state %0d required 4", state_a);
        else pass_cnt++;
        t0 = tx_log_a.size();
        reset = 1'b0;
        #1;
        total_cnt++;
        if (outs_a !== '0 || outs_b !== '0)
            $display("FAIL reset_mid outputs: got %h/%h required 0", outs_a, outs_b);
        else pass_cnt++;
        repeat (3) tick();
        reset = 1'b1;
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        repeat (4) tick();
        total_cnt++;
        if (state_a !== 3'd0 || tx_log_a.size() !== t0 || proc_run_a !== 1'b0)
            $display("FAIL reset_mid after release: got state %0d extra tx %0d proc_run %b required 0 0 0",
                     state_a, tx_log_a.size() - t0, proc_run_a);
        else pass_cnt++;
        w0 = wr_addr_log.size();
        b = 8'($urandom);
        send_rx(b);
        total_cnt++;
        if (wr_addr_log.size() !== w0 + 1)
            $display("FAIL reset_mid next write count: got %0d required 1", wr_addr_log.size() - w0);
        else begin
            pass_cnt++;
            total_cnt++;
            if (wr_addr_log[w0] !== 0 || wr_data_log[w0] !== b)
                $display("FAIL reset_mid next write: got addr %0d data %h required addr 0 data %h",
                         wr_addr_log[w0], wr_data_log[w0], b);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run_dump();
        test_restart();
        test_overrun();
        test_back_to_back();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish before 500000 time units");
        $fatal(1);
    end

endmodule
